pio_in_debounced: RTL
=====================

# pio_in_debounced

Parametrised Avalon-MM input PIO for push-buttons and switches, the successor to the fixed 2-bit any-edge switch PIO. Adds:
- configurable width;
- a multi-stage synchroniser;
- a per-bit runtime-programmable debounce filter;
- per-bit rising/falling edge selection.

Edge events are latched in a write-1-to-clear capture register and masked onto a single level-sensitive irq for the Nios II interrupt controller.

## Interface
Parameters:
- WIDTH, 2, number of input bits (1..32)
- SYNC_STAGES, 2, synchroniser flops per bit (2..4)
- DB_RESET, 16'd0, reset value of the debounce threshold register

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset reset_n, asynchronous, active-low; clock clk
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq  out  1  level interrupt
- in_port  in  WIDTH  asynchronous pins

## Operation
Register map (unused bits read 0, writes ignored):
- 0 data: debounced stable value, RO.
- 1 raw: synchroniser output, RO.
- 2 irq_mask: RW, WIDTH bits.
- 3 edge_capture: RO, write-1-to-clear per bit.
- 4 rise_en: RW, WIDTH bits.
- 5 fall_en: RW, WIDTH bits.
- 6 db_thresh: RW, 16 bits (N).
- 7: reads 0.

Per-bit pipeline:
- **Synchroniser:** in_port passes through SYNC_STAGES flops, giving sync.
- **Debounce:** 16-bit counter cnt per bit. Each cycle:
  - if sync==stable: cnt<=0;
  - else if cnt>=N: stable<=sync and cnt<=0 (this cycle is a flip);
  - else cnt<=cnt+1.
  - A glitch shorter than N+1 cycles never reaches stable.
  - N=0 gives a one-cycle pass-through.
  - cnt saturates implicitly because it resets at N; no wrap is possible.
- **Edge event:** a flip 0→1 with rise_en[i]=1, or a flip 1→0 with fall_en[i]=1, sets edge_capture[i] on the same clock as the stable update.
- **Simultaneous clear and set:** a write-1 to edge_capture[i] in the same cycle as a new event leaves the bit SET. No event is lost.
- **Threshold change mid-count:** a db_thresh write takes effect on the next cycle's compare. Counters are not cleared; if cnt>=new N, the flip occurs on the next cycle.
- **Enables:** rise_en/fall_en/irq_mask changes do not alter existing capture bits.
- **irq:** irq = |(edge_capture & irq_mask), combinational from flops.

## Timing
- **Reset values:**
  - readdata=0, irq=0.
  - irq_mask=0, edge_capture=0, rise_en=0, fall_en=0, db_thresh=DB_RESET.
  - Synchroniser flops=0, stable=0, cnt=0.
  - A pin held high across reset therefore produces a rising flip after release (if enabled). This is intended.
- **Read latency 1:** readdata reflects the register addressed in cycle t at edge t+1. readdata updates every cycle regardless of chipselect, and has no side effects.
- **Writes:** take effect at the clock edge where chipselect && !write_n.
- **Pin latency:** a pin step stable from edge 0 changes stable, sets edge_capture and raises irq (if masked in) after SYNC_STAGES+N+1 edges.
- **Reset mid-operation:** asserting reset_n low clears all state immediately (asynchronous). Pending counts are discarded.

## Structure
- Package pio_pkg holds:
  - address constants (PIO_ADDR_DATA..PIO_ADDR_DBTHR);
  - DB_W=16;
  - the edge-select bit positions.
- Sub-module pio_debounce_bit (sync chain + counter + flip/rise/fall outputs) is instantiated WIDTH times in a generate loop.
- The top level holds the register file, capture logic, read mux and irq.

## Test plan
- **Reset and defaults:** reset with in_port=2'b11, N=0, rise_en=3. Response: after 4 clocks data reads 3 and edge_capture=3; irq=0 because mask=0. Write mask=3: irq=1 the next cycle.
- **Glitch filter:** N=5; pulse bit0 high for 5 cycles → data stays 0, no capture. Pulse for 8 cycles → data bit0=1 exactly SYNC_STAGES+6 edges after the rising pin edge.
- **Edge select:** rise_en=1, fall_en=2; toggle both bits up then down → capture shows bit0 only after the rise and bit1 only after the fall.
- **W1C race:** write edge_capture=1 in the same cycle bit0 flips → bit0 remains 1. A subsequent write of 1 with no event clears it, and irq drops the next cycle.
- **Threshold change mid-count:** N=100; after 50 cycles of a new level, write N=10 → stable flips on the cycle after the write.
- **WIDTH=32 build:** walking-one on all pins with N=0, all edges enabled → each capture bit sets individually, and readdata matches at 1-cycle latency.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared constants for the debounced input PIO: register addresses, counter width and
// edge-select bit positions.
package pio_pkg;

  localparam int unsigned DB_W = 16;

  localparam logic [2:0] PIO_ADDR_DATA  = 3'd0;
  localparam logic [2:0] PIO_ADDR_RAW   = 3'd1;
  localparam logic [2:0] PIO_ADDR_MASK  = 3'd2;
  localparam logic [2:0] PIO_ADDR_EDGE  = 3'd3;
  localparam logic [2:0] PIO_ADDR_RISE  = 3'd4;
  localparam logic [2:0] PIO_ADDR_FALL  = 3'd5;
  localparam logic [2:0] PIO_ADDR_DBTHR = 3'd6;

  // Bit positions within a per-pin edge event vector.
  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;

  typedef logic [DB_W-1:0] db_cnt_t;

endpackage

// File: rtl/pio_in_debounced_if.sv
// Avalon-MM slave bus bundle for the debounced input PIO.
interface pio_in_debounced_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/pio_debounce_bit.sv
// One input pin: synchroniser chain, debounce counter and the rise/fall flip events that
// coincide with the stable-value update.
module pio_debounce_bit
  import pio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pin,
  input  db_cnt_t    thresh,
  output logic       sync,
  output logic       stable,
  output logic [1:0] edge_ev
);

  logic [SYNC_STAGES-1:0] sync_q;
  db_cnt_t                cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   flip;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pin};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign sync   = sync_q[SYNC_STAGES-1];
  assign stable = stable_q;

  // cnt never exceeds thresh while counting, so it cannot wrap.
  always_comb begin
    flip     = (sync != stable_q) && (cnt_q >= thresh);
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync == stable_q) begin
      cnt_d = '0;
    end else if (flip) begin
      stable_d = sync;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + db_cnt_t'(1);
    end
  end

  always_comb begin
    edge_ev            = '0;
    edge_ev[EDGE_RISE] = flip & sync;
    edge_ev[EDGE_FALL] = flip & ~sync;
  end

endmodule

// File: rtl/pio_in_debounced.sv
// Debounced Avalon-MM input PIO: register file, write-1-to-clear edge capture, registered
// read mux and a masked level interrupt.
module pio_in_debounced
  import pio_pkg::*;
#(
  parameter int unsigned    WIDTH       = 2,
  parameter int unsigned    SYNC_STAGES = 2,
  parameter logic [15:0]    DB_RESET    = 16'd0
) (
  input  logic                clk,
  input  logic                reset_n,
  pio_in_debounced_if.slave   bus,
  output logic                irq,
  input  logic [WIDTH-1:0]    in_port
);

  logic [WIDTH-1:0] mask_q, edge_q, edge_d, rise_q, fall_q;
  db_cnt_t          thresh_q;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] sync, stable, ev_rise, ev_fall, event_set, w1c;
  logic             wr;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [1:0] edge_ev;
    pio_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .pin     (in_port[i]),
      .thresh  (thresh_q),
      .sync    (sync[i]),
      .stable  (stable[i]),
      .edge_ev (edge_ev)
    );
    assign ev_rise[i] = edge_ev[EDGE_RISE];
    assign ev_fall[i] = edge_ev[EDGE_FALL];
  end

  assign wr        = bus.chipselect && !bus.write_n;
  assign event_set = (ev_rise & rise_q) | (ev_fall & fall_q);
  assign w1c       = (wr && bus.address == PIO_ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;
  // A new event wins over a same-cycle clear so no edge is lost.
  assign edge_d    = (edge_q & ~w1c) | event_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q   <= '0;
      edge_q   <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      thresh_q <= DB_RESET;
    end else begin
      edge_q <= edge_d;
      if (wr) begin
        case (bus.address)
          PIO_ADDR_MASK:  mask_q   <= bus.writedata[WIDTH-1:0];
          PIO_ADDR_RISE:  rise_q   <= bus.writedata[WIDTH-1:0];
          PIO_ADDR_FALL:  fall_q   <= bus.writedata[WIDTH-1:0];
          PIO_ADDR_DBTHR: thresh_q <= bus.writedata[DB_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      PIO_ADDR_DATA:  readdata_d[WIDTH-1:0] = stable;
      PIO_ADDR_RAW:   readdata_d[WIDTH-1:0] = sync;
      PIO_ADDR_MASK:  readdata_d[WIDTH-1:0] = mask_q;
      PIO_ADDR_EDGE:  readdata_d[WIDTH-1:0] = edge_q;
      PIO_ADDR_RISE:  readdata_d[WIDTH-1:0] = rise_q;
      PIO_ADDR_FALL:  readdata_d[WIDTH-1:0] = fall_q;
      PIO_ADDR_DBTHR: readdata_d[DB_W-1:0]  = thresh_q;
      default:        readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = |(edge_q & mask_q);

endmodule
